// File: rtl/spi_mst_core.sv
// SPI master engine: shifts up to 128 bits out on MOSI (MSB first)
// while capturing MISO, framed in 8- or 16-bit words, any CPOL/CPHA.
//
// Ports:
//   clk        system clock
//   rstn       asynchronous reset, active-high
//   mst_wfifo  transmit data, bit 127 sent first
//   mst_ctrl   [7] start (0->1 edge), [3:0] word count - 1
//   mst_rfifo  received data, first bit lands in bit 127
//   mst_status [7] busy, [6] done (sticky), [3:0] latched len
//   scl/ss/mosi/miso  SPI bus (ss active low)
module spi_mst_core #(
   parameter int MODE_16B = 0,
   parameter int CPOL     = 1,
   parameter int CPHA     = 0,
   parameter int CLK_DIV  = 4
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [127:0] mst_wfifo,
   input  logic [7:0]   mst_ctrl,
   output logic [127:0] mst_rfifo,
   output logic [7:0]   mst_status,
   output logic         scl,
   output logic         ss,
   output logic         mosi,
   input  logic         miso
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_XFER  = 2'd2;
   localparam logic [1:0] S_HOLD  = 2'd3;

   localparam int          DW      = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
   localparam logic        P_CPOL  = (CPOL != 0);
   localparam logic        P_CPHA  = (CPHA != 0);

   logic [1:0]    r_state;
   logic [DW-1:0] r_div;
   logic [7:0]    r_edge;
   logic [3:0]    r_len;
   logic [127:0]  r_sr;
   logic [127:0]  r_rfifo;
   logic          r_scl;
   logic          r_ss;
   logic          r_mosi;
   logic          r_done;
   logic          r_start_q;

   logic          w_start;
   logic          w_tick;
   logic          w_sample;
   logic [2:0]    w_len16;
   logic [7:0]    w_last;
   logic [6:0]    w_ridx;
   logic          w_unused;

   assign w_unused = ^mst_ctrl[6:4];

   assign w_start = mst_ctrl[7] & ~r_start_q & (r_state == S_IDLE);
   assign w_tick  = (r_div == DIV_MAX);

   // Even edge index = leading edge; CPHA picks which parity samples.
   assign w_sample = (r_edge[0] == P_CPHA);
   assign w_ridx   = 7'd127 - r_edge[7:1];

   // Index of the final (trailing) edge: 2*NBITS - 1.
   always_comb begin
      w_len16 = r_len[3] ? 3'd7 : r_len[2:0];
      w_last  = (MODE_16B != 0) ? {w_len16, 5'h1F} : {r_len, 4'hF};
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         r_state   <= S_IDLE;
         r_div     <= '0;
         r_edge    <= '0;
         r_len     <= '0;
         r_sr      <= '0;
         r_rfifo   <= '0;
         r_scl     <= P_CPOL;
         r_ss      <= 1'b1;
         r_mosi    <= 1'b0;
         r_done    <= 1'b0;
         r_start_q <= 1'b0;
      end else begin
         r_start_q <= mst_ctrl[7];
         unique case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state <= S_SETUP;
                  r_div   <= '0;
                  r_edge  <= '0;
                  r_len   <= mst_ctrl[3:0];
                  r_rfifo <= '0;
                  r_done  <= 1'b0;
                  r_ss    <= 1'b0;
                  // CPHA=0 presents bit 0 before the first edge;
                  // CPHA=1 drives it on the leading edge instead.
                  r_mosi  <= P_CPHA ? 1'b0 : mst_wfifo[127];
                  r_sr    <= P_CPHA ? mst_wfifo
                                    : {mst_wfifo[126:0], 1'b0};
               end
            end
            S_SETUP, S_XFER: begin
               r_div <= w_tick ? '0 : r_div + DW'(1);
               if (w_tick) begin
                  r_scl  <= ~r_scl;
                  r_edge <= r_edge + 8'd1;
                  if (w_sample) begin
                     r_rfifo[w_ridx] <= miso;
                  end else begin
                     r_mosi <= r_sr[127];
                     r_sr   <= {r_sr[126:0], 1'b0};
                  end
                  if (r_state == S_SETUP) begin
                     r_state <= S_XFER;
                  end else if (r_edge == w_last) begin
                     r_state <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               r_div <= w_tick ? '0 : r_div + DW'(1);
               if (w_tick) begin
                  r_state <= S_IDLE;
                  r_ss    <= 1'b1;
                  r_mosi  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
         endcase
      end
   end

   assign scl        = r_scl;
   assign ss         = r_ss;
   assign mosi       = r_mosi;
   assign mst_rfifo  = r_rfifo;
   assign mst_status = {(r_state != S_IDLE), r_done, 2'b00, r_len};

endmodule

// File: tb/tb_spi_mst_core.sv
// Bench for spi_mst_core: five instances cover all CPOL/CPHA modes
// and 16-bit framing against a cycle-timing model of the SPI frame.
module tb_spi_mst_core;

   localparam int CD = 4;
   localparam int ND = 5;

   // Instance i: d0 (1,0) d1 (0,0) d2 (0,1) d3 (1,1) d4 16-bit (1,0)
   logic [ND-1:0] cpol_t = 5'b11001;
   logic [ND-1:0] cpha_t = 5'b01100;
   logic [ND-1:0] m16_t  = 5'b10000;

   logic          clk   = 1'b0;
   logic          rstn  = 1'b1;
   logic [127:0]  wfifo = '0;
   logic [7:0]    ctrl  = '0;
   logic          lb0   = 1'b0;
   logic          slv_miso = 1'b0;
   logic [127:0]  pat   = '0;

   logic [ND-1:0]        scl_v, ss_v, mosi_v, miso_v;
   logic [ND-1:0][127:0] rf_v;
   logic [ND-1:0][7:0]   st_v;

   int tests = 0;
   int fails = 0;

   // model state
   int            m_c = 0;
   logic [ND-1:0] m_act = '0;
   logic [ND-1:0] m_done = '0;
   int            m_nb  [ND];
   int            m_end [ND];
   logic [127:0]  m_rf  [ND];
   logic [127:0]  m_wf = '0;
   logic [3:0]    m_len = '0;

   int            pulses = 0;
   int            sfall = 0;
   logic [7:0]    mcap = '0;
   int            sidx = 0;

   always #5 clk = ~clk;

   assign miso_v[0]   = lb0 ? mosi_v[0] : slv_miso;
   assign miso_v[4:1] = mosi_v[4:1];

   spi_mst_core #(.MODE_16B(0), .CPOL(1), .CPHA(0), .CLK_DIV(CD)) u_d0 (
      .clk(clk), .rstn(rstn), .mst_wfifo(wfifo), .mst_ctrl(ctrl),
      .mst_rfifo(rf_v[0]), .mst_status(st_v[0]), .scl(scl_v[0]),
      .ss(ss_v[0]), .mosi(mosi_v[0]), .miso(miso_v[0]));
   spi_mst_core #(.MODE_16B(0), .CPOL(0), .CPHA(0), .CLK_DIV(CD)) u_d1 (
      .clk(clk), .rstn(rstn), .mst_wfifo(wfifo), .mst_ctrl(ctrl),
      .mst_rfifo(rf_v[1]), .mst_status(st_v[1]), .scl(scl_v[1]),
      .ss(ss_v[1]), .mosi(mosi_v[1]), .miso(miso_v[1]));
   spi_mst_core #(.MODE_16B(0), .CPOL(0), .CPHA(1), .CLK_DIV(CD)) u_d2 (
      .clk(clk), .rstn(rstn), .mst_wfifo(wfifo), .mst_ctrl(ctrl),
      .mst_rfifo(rf_v[2]), .mst_status(st_v[2]), .scl(scl_v[2]),
      .ss(ss_v[2]), .mosi(mosi_v[2]), .miso(miso_v[2]));
   spi_mst_core #(.MODE_16B(0), .CPOL(1), .CPHA(1), .CLK_DIV(CD)) u_d3 (
      .clk(clk), .rstn(rstn), .mst_wfifo(wfifo), .mst_ctrl(ctrl),
      .mst_rfifo(rf_v[3]), .mst_status(st_v[3]), .scl(scl_v[3]),
      .ss(ss_v[3]), .mosi(mosi_v[3]), .miso(miso_v[3]));
   spi_mst_core #(.MODE_16B(1), .CPOL(1), .CPHA(0), .CLK_DIV(CD)) u_d4 (
      .clk(clk), .rstn(rstn), .mst_wfifo(wfifo), .mst_ctrl(ctrl),
      .mst_rfifo(rf_v[4]), .mst_status(st_v[4]), .scl(scl_v[4]),
      .ss(ss_v[4]), .mosi(mosi_v[4]), .miso(miso_v[4]));

   // SPI slave for d0 (mode 1/0): bit 0 on select, next bit on trailing edge
   always @(negedge ss_v[0]) begin
      sidx = 0;
      slv_miso = pat[127];
   end
   always @(posedge scl_v[0]) begin
      if (ss_v[0] == 1'b0) begin
         sidx++;
         if (sidx < 128) slv_miso = pat[127 - sidx];
      end
   end

   // d0 leading (falling) edges: pulse count and mosi capture
   always @(negedge scl_v[0]) begin
      pulses++;
      mcap = {mcap[6:0], mosi_v[0]};
   end
   always @(negedge ss_v[0]) sfall++;

   function automatic void chk(string nm, int i,
                               logic [127:0] act, logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s d%0d: got %h want %h", nm, i, act, exp);
      end
   endfunction

   function automatic int nbits(int i, int len);
      int w;
      if (m16_t[i]) begin
         w = (len > 7) ? 8 : len + 1;
         return w * 16;
      end
      return (len + 1) * 8;
   endfunction

   task automatic arm(input logic [3:0] len, input logic [127:0] wf);
      logic [127:0] src;
      m_c   = -1;
      m_wf  = wf;
      m_len = len;
      for (int i = 0; i < ND; i++) begin
         src = (i == 0 && !lb0) ? pat : wf;
         m_nb[i]  = nbits(i, int'(len));
         m_end[i] = (2 * m_nb[i] + 1) * CD;
         m_rf[i]  = '0;
         for (int b = 0; b < m_nb[i]; b++) m_rf[i][127 - b] = src[127 - b];
         m_act[i]  = 1'b1;
         m_done[i] = 1'b0;
      end
   endtask

   task automatic start(input logic [3:0] len, input logic [127:0] wf);
      @(negedge clk); #1;
      ctrl = 8'h00;
      @(negedge clk); #1;
      wfifo = wf;
      ctrl  = {4'h8, len};
      arm(len, wf);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (m_act != '0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (m_act != '0) begin
         tests++;
         fails++;
         $display("FAIL wait_idle: got busy want idle after %0d cycles", n);
      end
      #1;
   endtask

   // per-cycle compare against the frame-timing model
   always @(negedge clk) begin
      int k;
      if (m_act != '0) m_c++;
      for (int i = 0; i < ND; i++) begin
         if (m_act[i] && m_c >= m_end[i]) begin
            m_act[i]  = 1'b0;
            m_done[i] = 1'b1;
         end
         if (m_act[i]) begin
            chk("scl", i, 128'(scl_v[i]),
                128'(cpol_t[i] ^ (((m_c / CD) % 2) == 1)));
            chk("ss", i, 128'(ss_v[i]), 128'(0));
            chk("stat_hi", i, 128'(st_v[i][7:4]), 128'(4'b1000));
            if (!m16_t[i]) chk("len", i, 128'(st_v[i][3:0]), 128'(m_len));
            if (m_c == 0) chk("rx_clr", i, rf_v[i], 128'(0));
            if ((m_c + 1) % CD == 0) begin
               k = (m_c + 1) / CD - 1;
               if (k < 2 * m_nb[i] && (k % 2) == int'(cpha_t[i]))
                  chk("mosi", i, 128'(mosi_v[i]), 128'(m_wf[127 - k / 2]));
            end
         end else begin
            chk("idle_scl", i, 128'(scl_v[i]), 128'(cpol_t[i]));
            chk("idle_ss", i, 128'(ss_v[i]), 128'(1));
            chk("idle_mosi", i, 128'(mosi_v[i]), 128'(0));
            chk("idle_rx", i, rf_v[i], m_rf[i]);
            chk("idle_st", i, 128'(st_v[i][7:4]),
                128'({1'b0, m_done[i], 2'b00}));
            if (!m16_t[i]) chk("idle_len", i, 128'(st_v[i][3:0]), 128'(m_len));
         end
      end
   end

   initial begin
      logic [127:0] wf;
      int n;
      for (int i = 0; i < ND; i++) begin
         m_rf[i]  = '0;
         m_nb[i]  = 0;
         m_end[i] = 0;
      end
      // reset values
      repeat (2) @(negedge clk);
      #1;
      for (int i = 0; i < ND; i++) begin
         chk("rst_scl", i, 128'(scl_v[i]), 128'(cpol_t[i]));
         chk("rst_ss", i, 128'(ss_v[i]), 128'(1));
         chk("rst_mosi", i, 128'(mosi_v[i]), 128'(0));
         chk("rst_rx", i, rf_v[i], 128'(0));
         chk("rst_st", i, 128'(st_v[i]), 128'(0));
      end
      rstn = 1'b0;
      repeat (2) @(negedge clk);

      // A: 8-bit len=0, slave sends CA..., master sends 5A
      lb0 = 1'b0;
      pat = {4{32'hCAFE_EFAB}};
      pulses = 0;
      start(4'h0, {16{8'h5A}});
      wait_idle();
      chk("A_pulses", 0, 128'(pulses), 128'(8));
      chk("A_mosi", 0, 128'(mcap), 128'(8'h5A));
      chk("A_rx", 0, rf_v[0], {8'hCA, 120'h0});
      chk("A_st", 0, 128'(st_v[0]), 128'(8'h40));

      // B: len=F, slave sends BABEFACE x4
      pat = {4{32'hBABE_FACE}};
      pulses = 0;
      start(4'hF, 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
      wait_idle();
      chk("B_pulses", 0, 128'(pulses), 128'(128));
      chk("B_rx", 0, rf_v[0], {4{32'hBABE_FACE}});
      chk("B_st", 0, 128'(st_v[0]), 128'(8'h4F));

      // C: loopback all modes, len=F
      lb0 = 1'b1;
      wf = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
      start(4'hF, wf);
      wait_idle();
      for (int i = 0; i < ND; i++) chk("C_rx", i, rf_v[i], wf);

      // D: len=3 -> 32 bits (8-bit) / 64 bits (16-bit)
      wf = 128'hDEADBEEF_01234567_89ABCDEF_76543210;
      start(4'h3, wf);
      wait_idle();
      chk("D_rx16", 4, rf_v[4], {wf[127:64], 64'h0});
      chk("D_rx8", 1, rf_v[1], {wf[127:96], 96'h0});

      // E: len=9 -> 16-bit clamps to 128, 8-bit gives 80
      wf = 128'hA5A53C3C_96966969_F00F0FF0_12345678;
      start(4'h9, wf);
      wait_idle();
      chk("E_rx16", 4, rf_v[4], wf);
      chk("E_rx8", 1, rf_v[1], {wf[127:48], 48'h0});

      // F: start held high ~2 transfers, inputs change while busy
      wf = 128'h13579BDF_2468ACE0_0F0F0F0F_C3C3C3C3;
      sfall = 0;
      start(4'hF, wf);
      repeat (100) @(negedge clk);
      #1;
      wfifo = ~wf;
      ctrl  = {4'h8, 4'h2};
      repeat (2 * 1028) @(negedge clk);
      #1;
      chk("F_once", 0, 128'(sfall), 128'(1));

      // start edge landing on the busy-falling clock is ignored
      wf = 128'hFEEDFACE_CAFEBABE_8BADF00D_DEADC0DE;
      sfall = 0;
      start(4'hF, wf);
      repeat (50) @(negedge clk);
      #1;
      ctrl = 8'h0F;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (m_c != m_end[0] - 1 && n < 3000);
      ctrl = 8'h8F;
      wait_idle();
      repeat (1100) @(negedge clk);
      #1;
      chk("F_edge_ign", 0, 128'(sfall), 128'(1));

      // G: fresh 0->1 edge gives a second transfer
      wf = 128'h0badcafe_11223344_55667788_99aabbcc;
      sfall = 0;
      start(4'hF, wf);
      wait_idle();
      chk("G_again", 0, 128'(sfall), 128'(1));
      chk("G_rx", 0, rf_v[0], wf);
      chk("G_st", 0, 128'(st_v[0]), 128'(8'h4F));

      // H: reset mid-transfer aborts immediately
      start(4'hF, 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE);
      repeat (300) @(negedge clk);
      #1;
      ctrl = 8'h00;
      rstn = 1'b1;
      m_act  = '0;
      m_done = '0;
      m_len  = '0;
      for (int i = 0; i < ND; i++) m_rf[i] = '0;
      #1;
      for (int i = 0; i < ND; i++) begin
         chk("H_scl", i, 128'(scl_v[i]), 128'(cpol_t[i]));
         chk("H_ss", i, 128'(ss_v[i]), 128'(1));
         chk("H_rx", i, rf_v[i], 128'(0));
         chk("H_st", i, 128'(st_v[i]), 128'(0));
      end
      repeat (3) @(negedge clk);
      #1;
      rstn = 1'b0;
      wf = 128'h5555AAAA_00000000_00000000_0000FFFF;
      start(4'h0, wf);
      wait_idle();
      chk("H_after", 2, rf_v[2], {wf[127:120], 120'h0});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
